// File: rtl/player_shot_engine.sv
// Player position, shot pool with fire cooldown, and lives/invulnerability FSM.
// Pixel flags are decoded combinationally from registered state and the current x/y.
module player_shot_engine #(
  parameter int unsigned X_START         = 320,
  parameter int unsigned Y_PLAYER        = 420,
  parameter int unsigned PLAYER_SIZE     = 32,
  parameter int unsigned X_LEFT          = 36,
  parameter int unsigned X_RIGHT         = 604,
  parameter int unsigned PLYR_VELOCITY   = 1,
  parameter int unsigned Y_TOP           = 36,
  parameter int unsigned NUM_SHOTS       = 4,
  parameter int unsigned SHOT_SPEED      = 4,
  parameter int unsigned SHOT_W          = 2,
  parameter int unsigned SHOT_LEN        = 8,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned LIVES           = 3,
  parameter int unsigned INVULN_FRAMES   = 64,
  parameter int unsigned FRAME_Y         = 481,
  localparam int unsigned SLOT_W = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pause,
  input  logic                 left,
  input  logic                 right,
  input  logic                 shoot,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 hit_valid,
  input  logic [SLOT_W-1:0]    hit_slot,
  input  logic                 player_hit,
  output logic [9:0]           x_plyr,
  output logic                 player_on,
  output logic                 shot_on,
  output logic [NUM_SHOTS-1:0] shot_slot_on,
  output logic [NUM_SHOTS-1:0] shots_active,
  output logic [3:0]           lives,
  output logic                 player_dead
);

  localparam int unsigned CD_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int unsigned IV_W    = ($clog2(INVULN_FRAMES + 1) > 4) ? $clog2(INVULN_FRAMES + 1) : 4;
  // Counter holds remaining idle ticks, so a fire every COOLDOWN_FRAMES ticks loads one less.
  localparam int unsigned CD_LOAD = (COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0;

  typedef enum logic [1:0] {ALIVE, HIT, DEAD} state_t;

  state_t              state, state_nxt;
  logic [3:0]          lives_nxt;
  logic [IV_W-1:0]     invuln, invuln_nxt;
  logic [CD_W-1:0]     cooldown, cooldown_nxt;
  logic [9:0]          x_nxt;
  logic [NUM_SHOTS-1:0] active_nxt;
  logic [9:0]          sx [NUM_SHOTS];
  logic [9:0]          sy [NUM_SHOTS];
  logic [9:0]          sx_nxt [NUM_SHOTS];
  logic [9:0]          sy_nxt [NUM_SHOTS];
  logic                step, any_free, fire;
  logic [SLOT_W-1:0]   fire_idx;

  assign step = (y == 10'(FRAME_Y)) && (x == 10'd0) && !pause;

  // Lowest-index free slot from the registered view.
  always_comb begin
    fire_idx = '0;
    any_free = 1'b0;
    for (int i = int'(NUM_SHOTS) - 1; i >= 0; i--) begin
      if (!shots_active[i]) begin
        fire_idx = SLOT_W'(i);
        any_free = 1'b1;
      end
    end
  end

  assign fire = step && shoot && (state != DEAD) && (cooldown == '0) && any_free;

  always_comb begin
    state_nxt    = state;
    lives_nxt    = lives;
    invuln_nxt   = invuln;
    cooldown_nxt = cooldown;
    x_nxt        = x_plyr;
    active_nxt   = shots_active;
    sx_nxt       = sx;
    sy_nxt       = sy;

    if (step && state != DEAD) begin
      if (left && x_plyr >= 10'(X_LEFT + PLYR_VELOCITY))
        x_nxt = x_plyr - 10'(PLYR_VELOCITY);
      else if (right && (11'(x_plyr) + 11'(PLAYER_SIZE - 1 + PLYR_VELOCITY)) <= 11'(X_RIGHT))
        x_nxt = x_plyr + 10'(PLYR_VELOCITY);
    end

    if (step) begin
      if (fire)
        cooldown_nxt = CD_W'(CD_LOAD);
      else if (cooldown != '0)
        cooldown_nxt = cooldown - CD_W'(1);
      for (int i = 0; i < int'(NUM_SHOTS); i++) begin
        if (shots_active[i]) begin
          if (sy[i] < 10'(Y_TOP + SHOT_SPEED))
            active_nxt[i] = 1'b0;
          else
            sy_nxt[i] = sy[i] - 10'(SHOT_SPEED);
        end
      end
      if (fire) begin
        active_nxt[fire_idx] = 1'b1;
        sx_nxt[fire_idx]     = x_plyr + 10'(PLAYER_SIZE / 2 - SHOT_W / 2);
        sy_nxt[fire_idx]     = 10'(Y_PLAYER - SHOT_LEN);
      end
    end

    // Hit clear overrides motion; only slots already active can be cleared.
    if (hit_valid && !pause) begin
      for (int i = 0; i < int'(NUM_SHOTS); i++) begin
        if (shots_active[i] && hit_slot == SLOT_W'(i))
          active_nxt[i] = 1'b0;
      end
    end

    case (state)
      ALIVE: begin
        if (player_hit && !pause && lives != 4'd0) begin
          lives_nxt = lives - 4'd1;
          if (lives == 4'd1) begin
            state_nxt = DEAD;
          end else begin
            state_nxt  = HIT;
            invuln_nxt = IV_W'(INVULN_FRAMES);
          end
        end
      end
      HIT: begin
        if (step) begin
          if (invuln <= IV_W'(1)) begin
            state_nxt  = ALIVE;
            invuln_nxt = '0;
          end else begin
            invuln_nxt = invuln - IV_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ALIVE;
      lives        <= 4'(LIVES);
      invuln       <= '0;
      cooldown     <= '0;
      x_plyr       <= 10'(X_START);
      shots_active <= '0;
      for (int i = 0; i < int'(NUM_SHOTS); i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
    end else begin
      state        <= state_nxt;
      lives        <= lives_nxt;
      invuln       <= invuln_nxt;
      cooldown     <= cooldown_nxt;
      x_plyr       <= x_nxt;
      shots_active <= active_nxt;
      sx           <= sx_nxt;
      sy           <= sy_nxt;
    end
  end

  assign player_dead = (state == DEAD);

  // Player box, hidden when dead and blinking on invuln[3] while hit.
  always_comb begin
    player_on = (x >= x_plyr) && (11'(x) <= 11'(x_plyr) + 11'(PLAYER_SIZE - 1)) &&
                (y >= 10'(Y_PLAYER)) && (11'(y) <= 11'(Y_PLAYER + PLAYER_SIZE - 1));
    if (state == DEAD || (state == HIT && invuln[3]))
      player_on = 1'b0;
  end

  // Scan high to low so the lowest overlapping slot wins.
  always_comb begin
    shot_slot_on = '0;
    for (int i = int'(NUM_SHOTS) - 1; i >= 0; i--) begin
      if (shots_active[i] &&
          (x >= sx[i]) && (11'(x) <= 11'(sx[i]) + 11'(SHOT_W - 1)) &&
          (y >= sy[i]) && (11'(y) <= 11'(sy[i]) + 11'(SHOT_LEN - 1))) begin
        shot_slot_on    = '0;
        shot_slot_on[i] = 1'b1;
      end
    end
  end

  assign shot_on = |shot_slot_on;

endmodule
